// File: rtl/lsu.sv
// lsu: RV32I load/store unit, one outstanding access, FSM IDLE->REQ->(WAIT)->RESP.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of truncating them.
module lsu #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic              ex_load_i,
  input  logic              ex_store_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [AWIDTH-1:0] ex_addr_i,
  input  logic [DWIDTH-1:0] ex_wdata_i,
  input  logic [4:0]        ex_rd_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              wb_valid_o,
  output logic              wb_we_o,
  output logic [4:0]        wb_rd_o,
  output logic [DWIDTH-1:0] wb_data_o,
  output logic              misaligned_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata, rdata, wd, ld;
  logic [2:0] f3;
  logic [4:0] rd;
  logic load, mis, acc_mis, byte_w, half_w;
  logic [3:0] be;
  logic [15:0] sh;
  // funct3[1:0] picks the width; reserved codes all land on 10/11 and so act as word
  always_comb begin
    byte_w = f3[1:0] == 2'b00;
    half_w = f3[1:0] == 2'b01;
    be = byte_w ? 4'b0001 << addr[1:0] : half_w ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    wd = byte_w ? {4{wdata[7:0]}} : half_w ? {2{wdata[15:0]}} : wdata;
    sh = 16'(mem_rdata_i >> (byte_w ? {addr[1:0], 3'b000} : {addr[1], 4'b0000}));
    ld = byte_w ? {{24{~f3[2] & sh[7]}}, sh[7:0]} :
         half_w ? {{16{~f3[2] & sh[15]}}, sh[15:0]} : mem_rdata_i;
  end
`ifdef LSU_MISALIGN_TRAP_EN
  assign acc_mis = (ex_funct3_i[1:0] == 2'b01 & ex_addr_i[0]) | (ex_funct3_i[1] & |ex_addr_i[1:0]);
  assign misaligned_o = wb_valid_o & mis;
`else
  assign acc_mis = 1'b0;
  assign misaligned_o = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      f3 <= '0;
      rd <= '0;
      load <= 1'b0;
      mis <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ex_valid_i && (ex_load_i || ex_store_i)) begin
          addr <= ex_addr_i;
          wdata <= ex_wdata_i;
          f3 <= ex_funct3_i;
          rd <= ex_rd_i;
          load <= ex_load_i;
          mis <= acc_mis;
          state <= acc_mis ? RESP : REQ;
        end
        REQ: if (mem_gnt_i) state <= load ? WAIT : RESP;
        WAIT: if (mem_rvalid_i) begin
          rdata <= ld;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign ex_ready_o = ~reset & (state == IDLE);
  assign mem_req_o = ~reset & (state == REQ);
  assign mem_we_o = mem_req_o & ~load;
  assign mem_addr_o = mem_req_o ? {addr[AWIDTH-1:2], 2'b00} : '0;
  assign mem_be_o = mem_req_o ? be : '0;
  assign mem_wdata_o = mem_we_o ? wd : '0;
  assign wb_valid_o = ~reset & (state == RESP);
  assign wb_we_o = wb_valid_o & load & ~mis;
  assign wb_rd_o = wb_valid_o ? rd : '0;
  assign wb_data_o = wb_we_o ? rdata : '0;
endmodule
